// File: rtl/operand_select_stage.sv
// Operand select stage: per-bit choice between two candidate A/B pairs, registered through a 2-entry skid buffer.
// Latency: 1 cycle from accept to out_valid when the main register is empty or emitting.
// Backpressure: in_ready = ~skid_valid, a register-derived signal with no combinational path from out_ready.
// Optional feature: define OPSEL_STATS_EN to count accepted beats with in_sel=1 (saturating, clearable).
module operand_select_stage #(
    parameter int                 WIDTH     = 4,
    parameter logic [WIDTH-1:0]   SEL_INV_A = '0,
    parameter logic [WIDTH-1:0]   SEL_INV_B = '0,
    parameter int                 CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sel,
    input  logic [WIDTH-1:0]     in_a0,
    input  logic [WIDTH-1:0]     in_b0,
    input  logic [WIDTH-1:0]     in_a1,
    input  logic [WIDTH-1:0]     in_b1,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_a,
    output logic [WIDTH-1:0]     out_b,
    output logic                 out_sel,
    input  logic                 stat_clr,
    output logic [CNT_WIDTH-1:0] stat_sel1_cnt
);

    // Main register feeds the outputs; skid register absorbs the one beat
    // that can arrive while main is stalled.
    logic             main_valid;
    logic [WIDTH-1:0] main_a;
    logic [WIDTH-1:0] main_b;
    logic             main_sel;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_a;
    logic [WIDTH-1:0] skid_b;
    logic             skid_sel;

    logic [WIDTH-1:0] sel_mask_a;
    logic [WIDTH-1:0] sel_mask_b;
    logic [WIDTH-1:0] pick_a;
    logic [WIDTH-1:0] pick_b;
    logic             accept;
    logic             emit;

    // Per-bit effective select: the beat select, flipped where the mask bit is set.
    always_comb begin
        sel_mask_a = {WIDTH{in_sel}} ^ SEL_INV_A;
        sel_mask_b = {WIDTH{in_sel}} ^ SEL_INV_B;
        pick_a     = (in_a1 & sel_mask_a) | (in_a0 & ~sel_mask_a);
        pick_b     = (in_b1 & sel_mask_b) | (in_b0 & ~sel_mask_b);
    end

    // Handshake terms; nothing is accepted while reset is asserted.
    assign in_ready  = ~skid_valid;
    assign accept    = in_valid & ~skid_valid & ~rst;
    assign emit      = main_valid & out_ready;

    assign out_valid = main_valid;
    assign out_a     = main_a;
    assign out_b     = main_b;
    assign out_sel   = main_sel;

    // Skid-buffer state update: refill main from skid first (preserves order),
    // otherwise from the input; park the input in skid only when main stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_a     <= '0;
            main_b     <= '0;
            main_sel   <= 1'b0;
            skid_valid <= 1'b0;
            skid_a     <= '0;
            skid_b     <= '0;
            skid_sel   <= 1'b0;
        end else if (!main_valid || emit) begin
            if (skid_valid) begin
                // in_ready is low here, so no new beat competes for main.
                main_valid <= 1'b1;
                main_a     <= skid_a;
                main_b     <= skid_b;
                main_sel   <= skid_sel;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_valid <= 1'b1;
                main_a     <= pick_a;
                main_b     <= pick_b;
                main_sel   <= in_sel;
            end else begin
                // Data is left in place; only the valid flag drops.
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_a     <= pick_a;
            skid_b     <= pick_b;
            skid_sel   <= in_sel;
        end
    end

`ifdef OPSEL_STATS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
    logic [CNT_WIDTH-1:0] sel1_cnt;

    // Saturating count of accepted sel=1 beats; clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel1_cnt <= '0;
        end else if (stat_clr) begin
            sel1_cnt <= '0;
        end else if (accept && in_sel && !(&sel1_cnt)) begin
            sel1_cnt <= sel1_cnt + CNT_ONE;
        end
    end

    assign stat_sel1_cnt = sel1_cnt;
`else
    // Statistics disabled: the port stays for a stable interface, tied to zero.
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign stat_sel1_cnt   = '0;
`endif

endmodule

// File: doc/operand_select_stage.md
Name: operand_select_stage

Overview:
Parametrised, registered successor to the second-stage operand multiplexer of the modular adder/subtractor. Each beat carries two candidate operand pairs, (a0,b0) and (a1,b1), plus a select bit. The block picks one operand bit per position, with per-bit select inversion set by parameters, and emits the selected A/B pair through a 2-entry valid/ready skid buffer. It sits between first-stage candidate generation and the adder core, so it can be retimed without stalling upstream logic combinationally.

Parameters:
WIDTH, 4, operand width in bits (>=1)
SEL_INV_A, 0, WIDTH-bit mask; bit i set -> A bit i uses inverted select
SEL_INV_B, 0, WIDTH-bit mask; bit i set -> B bit i uses inverted select
CNT_WIDTH, 16, width of the statistics counter (used only with OPSEL_STATS_EN)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_sel  in  1  candidate select for this beat
in_a0  in  WIDTH  candidate A, set 0
in_b0  in  WIDTH  candidate B, set 0
in_a1  in  WIDTH  candidate A, set 1
in_b1  in  WIDTH  candidate B, set 1
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_a  out  WIDTH  selected A
out_b  out  WIDTH  selected B
out_sel  out  1  in_sel of the beat on the output
stat_clr  in  1  clear statistics counter (OPSEL_STATS_EN only)
stat_sel1_cnt  out  CNT_WIDTH  accepted beats with in_sel=1 (OPSEL_STATS_EN only)

Behaviour:
- Selection per bit i: ea = in_sel ^ SEL_INV_A[i]; out_a[i] = ea ? in_a1[i] : in_a0[i]. B uses SEL_INV_B the same way.
- Selection is evaluated at acceptance. Registers store selected values plus sel; candidates are not stored.
- Accept = in_valid & in_ready. Emit = out_valid & out_ready.
- Storage: main register drives the outputs; skid register holds one extra beat.
- in_ready = ~skid_valid. It is a pure register output, with no combinational path from out_ready.
- Latency: a beat accepted in cycle N appears on the outputs in cycle N+1 if main is empty or emitting in N.
- Per-cycle update:
  - main empty, or main emitting and skid empty: accepted beat loads main.
  - main emitting and skid full: skid moves to main. in_ready was 0, so no accept can occur.
  - main full, not emitting, accept: beat goes to skid; in_ready drops next cycle.
  - main emitting, no accept, skid empty: out_valid -> 0.
- Order is strict FIFO. No beat is dropped or duplicated.
- Output data is stable while out_valid=1 and out_ready=0.
- Reset:
  - out_valid=0, skid_valid=0, in_ready=1, out_a=0, out_b=0, out_sel=0, stat_sel1_cnt=0.
  - in_valid is ignored while rst=1.
  - Reset mid-transfer discards both stored beats, with no emission after reset.
- Simultaneous accept and emit at full throughput (skid empty): main reloads; sustained 1 beat/cycle.

Optional Feature:
- Macro OPSEL_STATS_EN.
- Defined:
  - stat_sel1_cnt increments on every accept with in_sel=1 and saturates at all-ones.
  - stat_clr has priority over increment; the counter is 0 the cycle after stat_clr.
  - Counter resets to 0.
- Undefined:
  - stat_clr and stat_sel1_cnt ports still exist; stat_sel1_cnt is tied to 0 and stat_clr is ignored.
  - No counter logic is synthesised.

Test Plan:
- WIDTH=4, masks 0; accept sel=0, a0=3,b0=5,a1=A,b1=C, out_ready=1 -> next cycle out_valid=1, out_a=3, out_b=5, out_sel=0; same beat with sel=1 -> out_a=A, out_b=C.
- SEL_INV_A=4'b0100, SEL_INV_B=4'b1000; sel=0, a0=0,a1=F,b0=0,b1=F -> out_a=4, out_b=8.
- Backpressure: out_ready=0, send beats 1,2 -> beat 1 on the outputs and held stable, in_ready=0 after beat 2, beat 3 not accepted. Raise out_ready -> outputs 1, 2, 3 in order on consecutive cycles.
- Streaming: in_valid=1, out_ready=1 for 8 cycles with values 0..7 -> outputs 0..7 on consecutive cycles, in_ready stays 1.
- Reset with main and skid full -> the cycle after reset, out_valid=0, in_ready=1, outputs 0; nothing old is emitted afterwards.
- OPSEL_STATS_EN, CNT_WIDTH=2: accept 5 beats with sel=1 and 2 with sel=0 -> count saturates at 3; pulse stat_clr together with a sel=1 accept -> count 0.
